// File: rtl/scan_chain_ctrl_pkg.sv
// Shared types and limits for the scan-chain load/capture/unload controller.
package scan_ctrl_pkg;

    localparam int unsigned CHAIN_LEN_MIN = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        DONE
    } state_t;

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load shift register: shifts left, serial data enters bit 0, bit WIDTH-1 leaves first.
module scan_shift_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], ser_in};
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Drives SE/SI of one negedge scan chain through load, capture and unload,
// then compares the unloaded response against a masked expected value.
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 16
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic [CHAIN_LEN-1:0] expect_in,
    input  logic [CHAIN_LEN-1:0] mask_in,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response_out,
    output logic                 mismatch
);

    localparam int unsigned CW = $clog2(CHAIN_LEN);
    localparam logic [CW-1:0] CNT_LOAD_END   = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] CNT_UNLOAD_END = CW'(CHAIN_LEN - 2);

    if (CHAIN_LEN < CHAIN_LEN_MIN) begin : g_len_chk
        $error("scan_chain_ctrl: CHAIN_LEN must be at least %0d", CHAIN_LEN_MIN);
    end

    state_t               state;
    state_t               state_nx;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nx;
    logic                 accept;
    logic                 se_nx;
    logic                 busy_nx;
    logic                 done_nx;
    logic                 rsp_final;
    logic [CHAIN_LEN-1:0] rsp_full;
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] mask_q;
    logic [CHAIN_LEN-1:0] stim_q;
    logic [CHAIN_LEN-1:0] rsp_q;
    logic                 stim_low_unused;

    assign accept = (state == IDLE) && start;

    // Stimulus drains through the MSB and backfills zeros, so SI is already 0 after LOAD.
    scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_stim (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .load     (accept),
        .load_val (pattern_in),
        .shift    (state == LOAD),
        .ser_in   (1'b0),
        .q        (stim_q)
    );

    scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_rsp (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .load     (accept),
        .load_val ('0),
        .shift    ((state == CAPTURE) || (state == UNLOAD)),
        .ser_in   (SO),
        .q        (rsp_q)
    );

    assign SI              = stim_q[CHAIN_LEN-1];
    assign stim_low_unused = |stim_q[CHAIN_LEN-2:0];

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state        <= IDLE;
            cnt          <= '0;
            SE           <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            exp_q        <= '0;
            mask_q       <= '0;
            response_out <= '0;
            mismatch     <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            SE    <= se_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            if (accept) begin
                exp_q  <= expect_in;
                mask_q <= mask_in;
            end
            if (rsp_final) begin
                response_out <= rsp_full;
                mismatch     <= |((rsp_full ^ exp_q) & mask_q);
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                    cnt_nx   = '0;
                end
            end
            LOAD: begin
                if (cnt == CNT_LOAD_END) begin
                    state_nx = CAPTURE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            CAPTURE: begin
                state_nx = UNLOAD;
                cnt_nx   = '0;
            end
            UNLOAD: begin
                if (cnt == CNT_UNLOAD_END) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in flops on the same edge.
    always_comb begin
        se_nx     = (state_nx == LOAD) || (state_nx == UNLOAD);
        busy_nx   = (state_nx == LOAD) || (state_nx == CAPTURE) || (state_nx == UNLOAD);
        done_nx   = (state_nx == DONE);
        rsp_final = (state == UNLOAD) && (state_nx == DONE);
        rsp_full  = {rsp_q[CHAIN_LEN-2:0], SO};
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with behavioural negedge scan chains (N=4 and N=2).
module tb_scan_chain_ctrl;

    logic CLK  = 1'b0;
    logic RSTB = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic       start_a = 1'b0;
    logic [3:0] pat_a   = '0;
    logic [3:0] exp_a   = '0;
    logic [3:0] mask_a  = '0;
    logic [3:0] d_a     = '0;
    logic [3:0] chain_a = '0;
    logic       so_a, se_a, si_a, busy_a, done_a, mis_a;
    logic [3:0] resp_a;

    logic       start_b = 1'b0;
    logic [1:0] pat_b   = '0;
    logic [1:0] exp_b   = '0;
    logic [1:0] mask_b  = '0;
    logic [1:0] d_b     = '0;
    logic [1:0] chain_b = '0;
    logic       so_b, se_b, si_b, busy_b, done_b, mis_b;
    logic [1:0] resp_b;

    scan_chain_ctrl #(.CHAIN_LEN(4)) dut_a (
        .CLK(CLK), .RSTB(RSTB), .start(start_a), .pattern_in(pat_a),
        .expect_in(exp_a), .mask_in(mask_a), .SO(so_a), .SE(se_a), .SI(si_a),
        .busy(busy_a), .done(done_a), .response_out(resp_a), .mismatch(mis_a)
    );

    scan_chain_ctrl #(.CHAIN_LEN(2)) dut_b (
        .CLK(CLK), .RSTB(RSTB), .start(start_b), .pattern_in(pat_b),
        .expect_in(exp_b), .mask_in(mask_b), .SO(so_b), .SE(se_b), .SI(si_b),
        .busy(busy_b), .done(done_b), .response_out(resp_b), .mismatch(mis_b)
    );

    // Chain cells: shift on SE, otherwise capture functional D; never reset.
    always @(negedge CLK) begin
        if (se_a) chain_a <= {chain_a[2:0], si_a};
        else      chain_a <= d_a;
        if (se_b) chain_b <= {chain_b[0], si_b};
        else      chain_b <= d_b;
    end
    assign so_a = chain_a[3];
    assign so_b = chain_b[1];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_start(input int n, input logic v);
        if (n == 4) start_a = v;
        else        start_b = v;
    endtask

    task automatic set_vec(input int n, input logic [15:0] p, input logic [15:0] e, input logic [15:0] m);
        if (n == 4) begin
            pat_a = p[3:0]; exp_a = e[3:0]; mask_a = m[3:0];
        end else begin
            pat_b = p[1:0]; exp_b = e[1:0]; mask_b = m[1:0];
        end
    endtask

    task automatic sample(input int n, output logic se, output logic si, output logic bsy,
                          output logic dn, output logic mis, output logic [15:0] rsp);
        if (n == 4) begin
            se = se_a; si = si_a; bsy = busy_a; dn = done_a; mis = mis_a; rsp = 16'(resp_a);
        end else begin
            se = se_b; si = si_b; bsy = busy_b; dn = done_b; mis = mis_b; rsp = 16'(resp_b);
        end
    endtask

    // One full sequence; inputs are scrambled right after acceptance and start is
    // poked mid-sequence and in DONE, neither of which may have any effect.
    task automatic run_seq(input int n, input logic [15:0] pat, input logic [15:0] expv,
                           input logic [15:0] mask, input logic [15:0] rsp_exp, input logic mis_exp);
        logic se, si, bsy, dn, mis;
        logic [15:0] rsp;
        set_vec(n, pat, expv, mask);
        set_start(n, 1'b1);
        tick();
        set_start(n, 1'b0);
        set_vec(n, ~pat, ~expv, ~mask);
        for (int c = 1; c <= 2 * n; c++) begin
            sample(n, se, si, bsy, dn, mis, rsp);
            check_val("se", 32'(se), 32'(c != n + 1));
            check_val("si", 32'(si), (c <= n) ? 32'(pat[n - c]) : 32'd0);
            check_val("busy", 32'(bsy), 32'd1);
            check_val("done_early", 32'(dn), 32'd0);
            set_start(n, c == 3);
            tick();
        end
        sample(n, se, si, bsy, dn, mis, rsp);
        check_val("done", 32'(dn), 32'd1);
        check_val("busy_done", 32'(bsy), 32'd0);
        check_val("se_done", 32'(se), 32'd0);
        check_val("response", 32'(rsp), 32'(rsp_exp));
        check_val("mismatch", 32'(mis), 32'(mis_exp));
        set_start(n, 1'b1);
        tick();
        set_start(n, 1'b0);
        sample(n, se, si, bsy, dn, mis, rsp);
        check_val("done_pulse", 32'(dn), 32'd0);
        check_val("no_start_in_done", 32'(bsy), 32'd0);
        check_val("response_hold", 32'(rsp), 32'(rsp_exp));
        tick();
    endtask

    initial begin
        int n_cyc;
        #1;
        check_val("rst_se", 32'(se_a), 32'd0);
        check_val("rst_si", 32'(si_a), 32'd0);
        check_val("rst_busy", 32'(busy_a), 32'd0);
        check_val("rst_done", 32'(done_a), 32'd0);
        check_val("rst_resp", 32'(resp_a), 32'd0);
        check_val("rst_mis", 32'(mis_a), 32'd0);
        #20 RSTB = 1'b1;
        tick();

        d_a = 4'b0110;
        run_seq(4, 16'b1011, 16'b0110, 16'hF, 16'b0110, 1'b0);
        run_seq(4, 16'b1011, 16'b0111, 16'hF, 16'b0110, 1'b1);
        run_seq(4, 16'b1011, 16'b0111, 16'b1110, 16'b0110, 1'b0);

        d_b = 2'b01;
        run_seq(2, 16'b10, 16'b01, 16'b11, 16'b01, 1'b0);

        // start held high: sequences back to back, done every 2N+2 cycles
        set_vec(4, 16'b1011, 16'b0110, 16'hF);
        set_start(4, 1'b1);
        n_cyc = 0;
        while (!done_a && n_cyc < 40) begin
            tick();
            n_cyc++;
        end
        check_val("b2b_first_done", 32'(done_a), 32'd1);
        tick();
        n_cyc = 1;
        check_val("b2b_idle_gap", 32'(busy_a), 32'd0);
        while (!done_a && n_cyc < 40) begin
            tick();
            n_cyc++;
        end
        check_val("b2b_period", 32'(n_cyc), 32'd10);
        check_val("b2b_response", 32'(resp_a), 32'b0110);
        set_start(4, 1'b0);
        tick();
        tick();
        check_val("b2b_stop", 32'(busy_a), 32'd0);

        // reset in UNLOAD cycle 2
        set_start(4, 1'b1);
        tick();
        set_start(4, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check_val("pre_rst_resp", 32'(resp_a), 32'b0110);
        check_val("pre_rst_se", 32'(se_a), 32'd1);
        RSTB = 1'b0;
        #1;
        check_val("mid_rst_se", 32'(se_a), 32'd0);
        check_val("mid_rst_si", 32'(si_a), 32'd0);
        check_val("mid_rst_busy", 32'(busy_a), 32'd0);
        check_val("mid_rst_resp", 32'(resp_a), 32'd0);
        check_val("mid_rst_done", 32'(done_a), 32'd0);
        #2 RSTB = 1'b1;
        tick();

        d_a = 4'b1001;
        run_seq(4, 16'b0101, 16'b1001, 16'hF, 16'b1001, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
